mem_access_seq: RTL and testbench
=================================

# mem_access_seq

Control-unit memory sequencer that drives the CU side of the MEMORY block: address-mux select, CU address, read/write strobes and write data, and captures returned words. Serves two requesters, instruction fetch at the PC address and data load/store at a CU-supplied address, one transaction at a time. Sits between the control-unit FSM and MEMORY, and owns the instruction register and the load-data register.

## Interface
Parameters:
- READ_LAT, 1, cycles from the cycle with cu_read=1 until mb_data_out is valid (≥1)

Ports:
- CLK100MHZ  in  1  system clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- fetch_req  in  1  instruction-fetch request at current pc_addr (level)
- ls_req  in  1  load/store request (level)
- ls_we  in  1  1 = store, 0 = load; valid with ls_req
- ls_addr  in  8  load/store address
- ls_wdata  in  16  store data
- mb_data_out  in  16  data returned by MEMORY
- cu_mux_sel  out  1  0 = pc_addr, 1 = cu_addr
- cu_addr  out  8  registered copy of ls_addr
- cu_read  out  1  memory read strobe
- cu_write  out  1  memory write strobe
- mem_wdata  out  16  registered store data, drives mb_data_in
- ir  out  16  instruction register
- ld_data  out  16  last loaded word
- fetch_done  out  1  one-cycle pulse, ir updated
- ld_done  out  1  one-cycle pulse, ld_data updated
- st_done  out  1  one-cycle pulse, store committed
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, RD, WAIT, CAPTURE, WR.
- IDLE: sample requests. ls_req has priority over fetch_req.
  - ls_req & ls_we → WR
  - ls_req & !ls_we → RD (kind = load)
  - fetch_req only → RD (kind = fetch)
  - On accept, latch ls_addr into cu_addr, ls_wdata into mem_wdata, kind into a register.
- RD: cu_read=1; cu_mux_sel=0 for fetch, 1 for load → WAIT; wait counter loads READ_LAT-1.
- WAIT: cu_read=0, mux/addr held. Counter decrements; at 0, capture mb_data_out into ir (fetch) or ld_data (load) → CAPTURE.
- CAPTURE: pulse fetch_done or ld_done → IDLE.
- WR: cu_mux_sel=1, cu_write=1 for exactly one cycle, st_done pulses in the same cycle → IDLE.
- Requests are only sampled in IDLE. The requester holds req/operands until its done pulse and must drop req in the done cycle, or it is re-accepted.
- cu_read and cu_write are never high together. Neither is high outside RD/WR.
- ir and ld_data hold their value between transactions; only the matching kind updates each.

## Timing
- Reset (RST=1 at edge) values: state IDLE, cu_mux_sel 0, cu_addr 0, cu_read 0, cu_write 0, mem_wdata 0, ir 0, ld_data 0, all done pulses 0, busy 0.
- Fetch/load latency: accept edge → done pulse after READ_LAT+2 cycles.
  - READ_LAT=1 example: req seen at edge 0; RD in cycle 1; WAIT in cycle 2 (capture at its end); done in cycle 3.
- Store latency: accept edge → cu_write/st_done in the next cycle; busy for 1 cycle.
- Back-to-back: at least one IDLE cycle between transactions (IDLE accept cycle).
- Simultaneous fetch_req & ls_req in IDLE: the load/store is served. fetch_req stays pending and is accepted in the next IDLE cycle.
- Reset mid-transaction: abort at once, all strobes 0 in the next cycle, no done pulse, ir/ld_data cleared.
- Address/data width: 8-bit address, no wrap logic; 0xFF is valid.

## Structure
- Shared package mem_seq_pkg: state enum (IDLE, RD, WAIT, CAPTURE, WR), MUX_SEL_PC=1'b0, MUX_SEL_CU=1'b1, ADDR_W=8, DATA_W=16.
- No sub-module; the wait counter is inline, $clog2(READ_LAT+1) bits.

## Test plan
- Reset: assert RST 2 cycles mid-fetch → all outputs 0, busy 0, no fetch_done.
- Fetch: pc_addr=0x10, memory[0x10]=0x1234, fetch_req → cu_read for 1 cycle with sel=0; fetch_done at accept+3; ir=0x1234.
- Store then load: ls_we=1, ls_addr=0x80, ls_wdata=0xBEEF → one cu_write cycle with sel=1, cu_addr=0x80. Then load 0x80 → ld_data=0xBEEF at accept+3.
- Priority: fetch_req and load ls_req together → load served first, then fetch. ir is unchanged by the load; ld_done precedes fetch_done.
- READ_LAT=3: fetch → capture exactly 3 cycles after the RD cycle, fetch_done at accept+5.
- Held request: keep fetch_req high through fetch_done → second fetch starts after one IDLE cycle; strobes are never concurrent.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the CU-side memory sequencer.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    CAPTURE,
    WR
  } state_e;

  localparam logic MUX_SEL_PC = 1'b0;
  localparam logic MUX_SEL_CU = 1'b1;
  localparam int   ADDR_W     = 8;
  localparam int   DATA_W     = 16;

endpackage

// File: rtl/mem_access_seq.sv
// Sequences one fetch, load or store at a time against MEMORY; owns IR and load-data register.
// Fetch/load done READ_LAT+2 cycles after accept, store done 1 cycle after; requests sampled only in IDLE.
module mem_access_seq
  import mem_seq_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic              fetch_req,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [DATA_W-1:0] mb_data_out,
  output logic              cu_mux_sel,
  output logic [ADDR_W-1:0] cu_addr,
  output logic              cu_read,
  output logic              cu_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] ld_data,
  output logic              fetch_done,
  output logic              ld_done,
  output logic              st_done,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  state_e              state_q, state_d;
  logic                is_load_q, is_load_d;
  logic                mux_q, mux_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   ld_q, ld_d;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      mux_q     <= MUX_SEL_PC;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      ir_q      <= '0;
      ld_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      mux_q     <= mux_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      ir_q      <= ir_d;
      ld_q      <= ld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    mux_d      = mux_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    ld_d       = ld_q;
    cu_read    = 1'b0;
    cu_write   = 1'b0;
    fetch_done = 1'b0;
    ld_done    = 1'b0;
    st_done    = 1'b0;

    case (state_q)
      IDLE: begin
        // Load/store wins; a concurrent fetch stays pending until the next IDLE cycle.
        if (ls_req) begin
          state_d   = ls_we ? WR : RD;
          is_load_d = ~ls_we;
          mux_d     = MUX_SEL_CU;
          addr_d    = ls_addr;
          wdata_d   = ls_wdata;
        end else if (fetch_req) begin
          state_d   = RD;
          is_load_d = 1'b0;
          mux_d     = MUX_SEL_PC;
          addr_d    = ls_addr;
          wdata_d   = ls_wdata;
        end
      end
      RD: begin
        cu_read = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (is_load_q) ld_d = mb_data_out;
          else           ir_d = mb_data_out;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        fetch_done = ~is_load_q;
        ld_done    = is_load_q;
        state_d    = IDLE;
      end
      WR: begin
        cu_write = 1'b1;
        st_done  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cu_mux_sel = mux_q;
  assign cu_addr    = addr_q;
  assign mem_wdata  = wdata_q;
  assign ir         = ir_q;
  assign ld_data    = ld_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: READ_LAT=1 instance for most scenarios, READ_LAT=3 instance for latency.
module tb_mem_access_seq;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          total = 0;
  int          bad   = 0;

  logic        fetch_req, ls_req, ls_we;
  logic [7:0]  ls_addr, pc_addr;
  logic [15:0] ls_wdata, mb_a;
  logic        sel_a, rd_a, wr_a, fd_a, ldd_a, sd_a, busy_a;
  logic [7:0]  addr_a;
  logic [15:0] wd_a, ir_a, ld_a;

  logic        fetch_req_b, ls_req_b, ls_we_b;
  logic [7:0]  ls_addr_b, pc_addr_b;
  logic [15:0] ls_wdata_b, mb_b;
  logic        sel_b, rd_b, wr_b, fd_b, ldd_b, sd_b, busy_b;
  logic [7:0]  addr_b;
  logic [15:0] wd_b, ir_b, ld_b;

  mem_access_seq #(.READ_LAT(LAT_A)) dut_a (
    .CLK100MHZ(clk), .RST(rst), .fetch_req(fetch_req), .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .mb_data_out(mb_a), .cu_mux_sel(sel_a),
    .cu_addr(addr_a), .cu_read(rd_a), .cu_write(wr_a), .mem_wdata(wd_a), .ir(ir_a),
    .ld_data(ld_a), .fetch_done(fd_a), .ld_done(ldd_a), .st_done(sd_a), .busy(busy_a)
  );

  mem_access_seq #(.READ_LAT(LAT_B)) dut_b (
    .CLK100MHZ(clk), .RST(rst), .fetch_req(fetch_req_b), .ls_req(ls_req_b), .ls_we(ls_we_b),
    .ls_addr(ls_addr_b), .ls_wdata(ls_wdata_b), .mb_data_out(mb_b), .cu_mux_sel(sel_b),
    .cu_addr(addr_b), .cu_read(rd_b), .cu_write(wr_b), .mem_wdata(wd_b), .ir(ir_b),
    .ld_data(ld_b), .fetch_done(fd_b), .ld_done(ldd_b), .st_done(sd_b), .busy(busy_b)
  );

  // Environment memory (written by the DUT) and the bench's own expectation of its contents.
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic        poke_vld = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [15:0] poke_dat = '0;
  logic [15:0] pipe_a;
  logic [15:0] pipe_b [LAT_B];

  assign mb_a = pipe_a;
  assign mb_b = pipe_b[LAT_B-1];

  // Read data becomes valid READ_LAT cycles after the strobe; other cycles carry noise.
  always @(posedge clk) begin
    pipe_a    <= rd_a ? mem[sel_a ? addr_a : pc_addr] : 16'($urandom);
    pipe_b[0] <= rd_b ? mem[sel_b ? addr_b : pc_addr_b] : 16'($urandom);
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    if (wr_a) mem[addr_a] = wd_a;
    else if (poke_vld) mem[poke_addr] = poke_dat;
  end

  int conc_a = 0;
  always @(negedge clk) if (rd_a && wr_a) conc_a++;

  logic [15:0] exp_ir = '0;
  logic [15:0] exp_ld = '0;

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_vld = 1'b1; poke_addr = a; poke_dat = d;
    ref_mem[a] = d;
    @(negedge clk);
    poke_vld = 1'b0;
  endtask

  // kind: 0 fetch, 1 load, 2 store. Returns observations; callers compare.
  task automatic run_txn(input int kind, input logic [7:0] a, input logic [15:0] d,
                         output int lat, output int nrd, output int nwr,
                         output logic sel_seen, output logic [7:0] addr_seen,
                         output logic wrong_done);
    logic mine, other;
    @(negedge clk);
    if (kind == 0) begin
      pc_addr = a; fetch_req = 1'b1;
    end else begin
      ls_req = 1'b1; ls_we = (kind == 2); ls_addr = a; ls_wdata = d;
    end
    lat = 0; nrd = 0; nwr = 0; sel_seen = 1'b0; addr_seen = '0; wrong_done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rd_a || wr_a) begin sel_seen = sel_a; addr_seen = addr_a; end
      if (rd_a) nrd++;
      if (wr_a) nwr++;
      mine  = (kind == 0) ? fd_a : (kind == 1) ? ldd_a : sd_a;
      other = (fd_a | ldd_a | sd_a) & ~mine;
      if (other || (fd_a + ldd_a + sd_a) > 1) wrong_done = 1'b1;
      if (mine) begin lat = k; break; end
    end
    fetch_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) poke(8'(i), 16'($urandom));
    total++;
    if ({rd_a, wr_a, sel_a, fd_a, ldd_a, sd_a, busy_a} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0", {rd_a, wr_a, sel_a, fd_a, ldd_a, sd_a, busy_a});
    end
    total++;
    if ({addr_a, wd_a, ir_a, ld_a} !== 56'b0) begin
      bad++; $display("FAIL reset_regs got=%h want=0", {addr_a, wd_a, ir_a, ld_a});
    end
    total++;
    if ({busy_b, ir_b, ld_b, rd_b} !== 34'b0) begin
      bad++; $display("FAIL reset_b got=%h want=0", {busy_b, ir_b, ld_b, rd_b});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int lat, nrd, nwr; logic sel; logic [7:0] ad; logic wd;
    poke(8'h10, 16'h1234);
    run_txn(0, 8'h10, 16'h0, lat, nrd, nwr, sel, ad, wd);
    exp_ir = 16'h1234;
    total++;
    if (lat !== LAT_A + 2) begin bad++; $display("FAIL fetch_lat got=%0d want=%0d", lat, LAT_A + 2); end
    total++;
    if ({nrd, nwr} !== {32'd1, 32'd0} || sel !== 1'b0 || wd) begin
      bad++; $display("FAIL fetch_strobe rd=%0d wr=%0d sel=%b other=%b want rd=1 wr=0 sel=0", nrd, nwr, sel, wd);
    end
    total++;
    if (ir_a !== exp_ir) begin bad++; $display("FAIL fetch_ir got=%h want=%h", ir_a, exp_ir); end
  endtask

  task automatic test_store_load();
    int lat, nrd, nwr; logic sel; logic [7:0] ad; logic wd;
    run_txn(2, 8'h80, 16'hBEEF, lat, nrd, nwr, sel, ad, wd);
    ref_mem[8'h80] = 16'hBEEF;
    total++;
    if (lat !== 1 || nwr !== 1 || nrd !== 0 || sel !== 1'b1 || ad !== 8'h80 || wd) begin
      bad++; $display("FAIL store lat=%0d wr=%0d rd=%0d sel=%b addr=%h want 1/1/0/1/80", lat, nwr, nrd, sel, ad);
    end
    @(negedge clk);
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL store_busy got=%b want=0", busy_a); end
    run_txn(1, 8'h80, 16'h0, lat, nrd, nwr, sel, ad, wd);
    exp_ld = 16'hBEEF;
    total++;
    if (lat !== LAT_A + 2 || nrd !== 1 || sel !== 1'b1) begin
      bad++; $display("FAIL load lat=%0d rd=%0d sel=%b want %0d/1/1", lat, nrd, sel, LAT_A + 2);
    end
    total++;
    if (ld_a !== exp_ld || ir_a !== exp_ir) begin
      bad++; $display("FAIL load_data ld=%h ir=%h want ld=%h ir=%h", ld_a, ir_a, exp_ld, exp_ir);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done = 1'b0;
    poke(8'h20, 16'h5A5A);
    @(negedge clk);
    pc_addr = 8'h20; fetch_req = 1'b1;
    @(negedge clk);
    rst = 1'b1; fetch_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (fd_a || ldd_a || sd_a) saw_done = 1'b1;
    end
    total++;
    if ({rd_a, wr_a, busy_a} !== 3'b0 || ir_a !== 16'h0 || ld_a !== 16'h0) begin
      bad++; $display("FAIL reset_mid rd=%b wr=%b busy=%b ir=%h ld=%h want all 0", rd_a, wr_a, busy_a, ir_a, ld_a);
    end
    rst = 1'b0;
    exp_ir = '0; exp_ld = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (fd_a || ldd_a || sd_a || busy_a) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin bad++; $display("FAIL reset_mid_done got=1 want=0"); end
  endtask

  task automatic test_priority();
    int k_ld = 0, k_f = 0;
    logic [15:0] ir_at_ld = '0, ld_at_ld = '0;
    poke(8'h30, 16'hA0A0);
    poke(8'h31, 16'hC3C3);
    @(negedge clk);
    pc_addr = 8'h30; fetch_req = 1'b1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h31;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ldd_a && k_ld == 0) begin k_ld = k; ls_req = 1'b0; ir_at_ld = ir_a; ld_at_ld = ld_a; end
      if (fd_a) begin k_f = k; fetch_req = 1'b0; break; end
    end
    exp_ld = ref_mem[8'h31];
    total++;
    if (k_ld !== LAT_A + 2 || k_f !== 2 * (LAT_A + 2) + 1) begin
      bad++; $display("FAIL prio_order ld_done@%0d fetch_done@%0d want %0d,%0d", k_ld, k_f, LAT_A + 2, 2 * (LAT_A + 2) + 1);
    end
    total++;
    if (ld_at_ld !== exp_ld || ir_at_ld !== exp_ir) begin
      bad++; $display("FAIL prio_load ld=%h ir=%h want ld=%h ir=%h", ld_at_ld, ir_at_ld, exp_ld, exp_ir);
    end
    exp_ir = ref_mem[8'h30];
    total++;
    if (ir_a !== exp_ir) begin bad++; $display("FAIL prio_fetch ir=%h want=%h", ir_a, exp_ir); end
  endtask

  task automatic test_back_to_back();
    int c0 = conc_a;
    int t1 = 0, t2 = 0;
    poke(8'h40, 16'h7E57);
    @(negedge clk);
    pc_addr = 8'h40; fetch_req = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (fd_a) begin
        if (t1 == 0) t1 = k;
        else begin t2 = k; break; end
      end
    end
    fetch_req = 1'b0;
    exp_ir = ref_mem[8'h40];
    total++;
    if (t1 !== LAT_A + 2 || t2 !== 2 * (LAT_A + 2) + 1) begin
      bad++; $display("FAIL held_fetch done@%0d,%0d want %0d,%0d", t1, t2, LAT_A + 2, 2 * (LAT_A + 2) + 1);
    end
    total++;
    if (conc_a !== c0 || ir_a !== exp_ir) begin
      bad++; $display("FAIL held_strobes conc=%0d ir=%h want conc=%0d ir=%h", conc_a, ir_a, c0, exp_ir);
    end
  endtask

  task automatic test_random();
    int lat, nrd, nwr, kind, want_lat; logic sel; logic [7:0] ad, a; logic wd; logic [15:0] d;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a    = (i == 0) ? 8'hFF : 8'hF8 + 8'($urandom_range(0, 7));
      d    = 16'($urandom);
      run_txn(kind, a, d, lat, nrd, nwr, sel, ad, wd);
      if (kind == 0) exp_ir = ref_mem[a];
      else if (kind == 1) exp_ld = ref_mem[a];
      else ref_mem[a] = d;
      want_lat = (kind == 2) ? 1 : LAT_A + 2;
      total++;
      if (lat !== want_lat || wd || (kind != 0 && ad !== a) || sel !== (kind != 0)) begin
        bad++; $display("FAIL rand_txn i=%0d kind=%0d lat=%0d addr=%h sel=%b want lat=%0d addr=%h", i, kind, lat, ad, sel, want_lat, a);
      end
      total++;
      if (ir_a !== exp_ir || ld_a !== exp_ld) begin
        bad++; $display("FAIL rand_regs i=%0d ir=%h ld=%h want ir=%h ld=%h", i, ir_a, ld_a, exp_ir, exp_ld);
      end
    end
  endtask

  task automatic test_lat3();
    int kf = 0, kl = 0, nrd = 0;
    @(negedge clk);
    pc_addr_b = 8'h10; fetch_req_b = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rd_b) nrd++;
      if (fd_b) begin kf = k; break; end
    end
    fetch_req_b = 1'b0;
    total++;
    if (kf !== LAT_B + 2 || nrd !== 1 || ir_b !== ref_mem[8'h10]) begin
      bad++; $display("FAIL lat3_fetch done@%0d rd=%0d ir=%h want %0d/1/%h", kf, nrd, ir_b, LAT_B + 2, ref_mem[8'h10]);
    end
    @(negedge clk);
    ls_req_b = 1'b1; ls_we_b = 1'b0; ls_addr_b = 8'hFF;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ldd_b) begin kl = k; break; end
    end
    ls_req_b = 1'b0;
    total++;
    if (kl !== LAT_B + 2 || ld_b !== ref_mem[8'hFF]) begin
      bad++; $display("FAIL lat3_load done@%0d ld=%h want %0d/%h", kl, ld_b, LAT_B + 2, ref_mem[8'hFF]);
    end
  endtask

  initial begin
    rst = 1'b1;
    fetch_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; pc_addr = '0;
    fetch_req_b = 1'b0; ls_req_b = 1'b0; ls_we_b = 1'b0; ls_addr_b = '0; ls_wdata_b = '0; pc_addr_b = '0;
    test_reset();
    test_fetch();
    test_store_load();
    test_reset_mid();
    test_priority();
    test_back_to_back();
    test_random();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
